// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte tables, GF(2^8) helpers and round functions
// Byte k of a 128-bit state lives at bits [8k +: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

  localparam int nb = 4;

  typedef enum logic [1:0] {
    st_idle,
    st_round,
    st_final
  } dec_state_e;

  localparam logic [0:2047] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] inv_sbox_tbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_tbl[8*b +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return inv_sbox_tbl[8*b +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return r;
  endfunction

  // Row r of output column c comes from column c-r, i.e. row r rotates right by r.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < nb; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(4*c + row) +: 8] = s[8*(4*((c - row + nb) % nb) + row) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < nb; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational inverse-cipher round
// The last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         last_round,
  output logic [0:127] state_out
);

  logic [0:127] keyed;

  always_comb begin
    keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
    state_out = last_round ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/decrypt.sv
// rtl/decrypt.sv - iterative AES inverse cipher, one round per clock
// Accept edge applies round key nr; ROUND walks keys nr-1..1; FINAL applies key 0.
module decrypt
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:127]           in,
  input  logic [0:128*(nr+1)-1]  key_e,
  output logic [0:127]           out,
  output logic                   busy,
  output logic                   done
);

  localparam int cnt_w = $clog2(nr + 1);
  // An nk/nr pair that does not describe a real AES variant never starts a block.
  localparam bit cfg_ok = (nr == nk + 6);

  dec_state_e          fsm_q, fsm_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [0:127]        state_q, state_d;
  logic [0:127]        out_q, out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [cnt_w-1:0]    rk_idx;
  logic [0:127]        round_key;
  logic [0:127]        round_out;
  logic                last_round;

  always_comb begin
    case (fsm_q)
      st_idle:  rk_idx = cnt_w'(nr);
      st_round: rk_idx = cnt_q;
      default:  rk_idx = '0;
    endcase
    round_key  = key_e[128*rk_idx +: 128];
    last_round = (fsm_q == st_final);
  end

  aes_inv_round u_round (
    .state_in   (state_q),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (fsm_q)
      st_idle: begin
        if (start && cfg_ok) begin
          state_d = in ^ round_key;
          cnt_d   = cnt_w'(nr - 1);
          busy_d  = 1'b1;
          fsm_d   = st_round;
        end
      end
      st_round: begin
        state_d = round_out;
        cnt_d   = cnt_q - cnt_w'(1);
        if (cnt_q == cnt_w'(1)) fsm_d = st_final;
      end
      st_final: begin
        out_d  = round_out;
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = st_idle;
      end
      default: fsm_d = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= st_idle;
      cnt_q   <= '0;
      state_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
